// File: rtl/tile_pkg.sv
// Shared definitions for the tile shuffler.
//   - default board sizes, ID width and LFSR setup
//   - FSM state encoding
//   - scale_draw(): maps a random value onto 0..i without a modulo
package tile_pkg;

    localparam int unsigned N_EDGE_DEF   = 24;
    localparam int unsigned N_CENTER_DEF = 12;
    localparam int unsigned IDX_W_DEF    = 5;
    localparam int unsigned LFSR_W_DEF   = 16;
    localparam int unsigned RND_W_DEF    = 8;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] SEED_DEF  = 16'hACE1;

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StShEdge,
        StShCenter,
        StPublish
    } state_e;

    // j = (r * (i + 1)) >> rnd_w with r < 2^rnd_w, so 0 <= j <= i always holds.
    function automatic int unsigned scale_draw(input int unsigned r, input int unsigned i,
                                               input int unsigned rnd_w);
        return (r * (i + 1)) >> rnd_w;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR, right-shifting, with synchronous load.
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset, q returns to SEED
//   load     take load_val on the next edge (SEED if load_val is zero)
//   load_val value to load
//   q        current LFSR state
module lfsr_galois #(
    parameter int unsigned        LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else if (load) begin
            // An all-zero state would lock the LFSR up forever.
            q_q <= (load_val == '0) ? SEED : load_val;
        end else if (q_q[0]) begin
            q_q <= (q_q >> 1) ^ TAPS;
        end else begin
            q_q <= q_q >> 1;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tile_shuffler.sv
// Random board layout generator: Fisher-Yates shuffle of the edge-tile IDs and then
// the center-tile IDs, driven by a free-running LFSR, with double-buffered outputs.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   start          request a shuffle (sampled only while idle)
//   seed_load,seed reseed the LFSR (zero seed maps to SEED)
//   busy           shuffle in progress
//   done           one-cycle pulse when new orders are published
//   valid          at least one layout has been published since reset
//   edge_order     slot k at [k*IDX_W +: IDX_W]
//   center_order   same packing for the center tiles
module tile_shuffler
    import tile_pkg::*;
#(
    parameter int unsigned       N_EDGE   = N_EDGE_DEF,
    parameter int unsigned       N_CENTER = N_CENTER_DEF,
    parameter int unsigned       IDX_W    = IDX_W_DEF,
    parameter int unsigned       LFSR_W   = LFSR_W_DEF,
    parameter int unsigned       RND_W    = RND_W_DEF,
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(SEED_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      seed_load,
    input  logic [LFSR_W-1:0]         seed,
    output logic                      busy,
    output logic                      done,
    output logic                      valid,
    output logic [N_EDGE*IDX_W-1:0]   edge_order,
    output logic [N_CENTER*IDX_W-1:0] center_order
);

    localparam int unsigned EW = (N_EDGE > 1) ? $clog2(N_EDGE) : 1;
    localparam int unsigned CW = (N_CENTER > 1) ? $clog2(N_CENTER) : 1;
    localparam logic [LFSR_W-1:0] RND_MASK = LFSR_W'((64'd1 << RND_W) - 64'd1);

    state_e                      state_q, state_d;
    logic [EW-1:0]               i_e_q;
    logic [CW-1:0]               i_c_q;
    logic [IDX_W-1:0]            work_e_q [N_EDGE];
    logic [IDX_W-1:0]            work_c_q [N_CENTER];
    logic [N_EDGE*IDX_W-1:0]     edge_order_q;
    logic [N_CENTER*IDX_W-1:0]   center_order_q;
    logic                        busy_q, done_q, valid_q;
    logic [LFSR_W-1:0]           lfsr_q;
    logic [LFSR_W-1:0]           rnd;
    logic [EW-1:0]               j_e;
    logic [CW-1:0]               j_c;

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .TAPS   (LFSR_W'(LFSR_TAPS)),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (seed_load),
        .load_val (seed),
        .q        (lfsr_q)
    );

    assign rnd = lfsr_q & RND_MASK;
    assign j_e = EW'(scale_draw(32'(rnd), 32'(i_e_q), RND_W));
    assign j_c = CW'(scale_draw(32'(rnd), 32'(i_c_q), RND_W));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StInit;
            end
            StInit: begin
                // A set of one tile has nothing to shuffle and skips its phase.
                if (N_EDGE > 1)        state_d = StShEdge;
                else if (N_CENTER > 1) state_d = StShCenter;
                else                   state_d = StPublish;
            end
            StShEdge: begin
                if (i_e_q == EW'(1)) state_d = (N_CENTER > 1) ? StShCenter : StPublish;
            end
            StShCenter: begin
                if (i_c_q == CW'(1)) state_d = StPublish;
            end
            StPublish: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            i_e_q   <= '0;
            i_c_q   <= '0;
            for (int k = 0; k < N_EDGE; k++) begin
                work_e_q[k]                    <= IDX_W'(k);
                edge_order_q[k*IDX_W +: IDX_W] <= IDX_W'(k);
            end
            for (int k = 0; k < N_CENTER; k++) begin
                work_c_q[k]                      <= IDX_W'(k);
                center_order_q[k*IDX_W +: IDX_W] <= IDX_W'(k);
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) busy_q <= 1'b1;
                end
                StInit: begin
                    for (int k = 0; k < N_EDGE; k++)   work_e_q[k] <= IDX_W'(k);
                    for (int k = 0; k < N_CENTER; k++) work_c_q[k] <= IDX_W'(k);
                    i_e_q <= EW'(N_EDGE - 1);
                    i_c_q <= CW'(N_CENTER - 1);
                end
                StShEdge: begin
                    work_e_q[i_e_q] <= work_e_q[j_e];
                    work_e_q[j_e]   <= work_e_q[i_e_q];
                    i_e_q           <= i_e_q - EW'(1);
                    if (i_e_q == EW'(1)) i_c_q <= CW'(N_CENTER - 1);
                end
                StShCenter: begin
                    work_c_q[i_c_q] <= work_c_q[j_c];
                    work_c_q[j_c]   <= work_c_q[i_c_q];
                    i_c_q           <= i_c_q - CW'(1);
                end
                StPublish: begin
                    for (int k = 0; k < N_EDGE; k++)
                        edge_order_q[k*IDX_W +: IDX_W] <= work_e_q[k];
                    for (int k = 0; k < N_CENTER; k++)
                        center_order_q[k*IDX_W +: IDX_W] <= work_c_q[k];
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign valid        = valid_q;
    assign edge_order   = edge_order_q;
    assign center_order = center_order_q;

endmodule

// File: tb/tb_tile_shuffler.sv
module tb_tile_shuffler;

    localparam int NE  = 24;
    localparam int NC  = 12;
    localparam int IW  = 5;
    localparam int LAT = 36;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              seed_load;
    logic [15:0]       seed;
    logic              busy, done, valid;
    logic [NE*IW-1:0]  edge_order;
    logic [NC*IW-1:0]  center_order;

    tile_shuffler #(
        .N_EDGE   (NE),
        .N_CENTER (NC),
        .IDX_W    (IW),
        .LFSR_W   (16),
        .RND_W    (8),
        .SEED     (16'hACE1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .seed_load    (seed_load),
        .seed         (seed),
        .busy         (busy),
        .done         (done),
        .valid        (valid),
        .edge_order   (edge_order),
        .center_order (center_order)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    // Reference LFSR: one Galois step of x^16+x^14+x^13+x^11+1, tracked every cycle.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst)            m_lfsr <= 16'hACE1;
        else if (seed_load) m_lfsr <= (seed == 16'h0) ? 16'hACE1 : seed;
        else                m_lfsr <= lfsr_step(m_lfsr);
    end

    logic [NE*IW-1:0] exp_e, pub_e, ident_e;
    logic [NC*IW-1:0] exp_c, pub_c, ident_c;

    // Fisher-Yates over plain int arrays; l0 is the LFSR value during the INIT cycle,
    // and each swap consumes the next LFSR value.
    task automatic model_shuffle(input logic [15:0] l0);
        int e[NE];
        int c[NC];
        int j, t;
        logic [15:0] l;
        l = l0;
        for (int k = 0; k < NE; k++) e[k] = k;
        for (int k = 0; k < NC; k++) c[k] = k;
        for (int i = NE - 1; i >= 1; i--) begin
            l = lfsr_step(l);
            j = (int'(l % 16'd256) * (i + 1)) / 256;
            t = e[i]; e[i] = e[j]; e[j] = t;
        end
        for (int i = NC - 1; i >= 1; i--) begin
            l = lfsr_step(l);
            j = (int'(l % 16'd256) * (i + 1)) / 256;
            t = c[i]; c[i] = c[j]; c[j] = t;
        end
        for (int k = 0; k < NE; k++) exp_e[k*IW +: IW] = IW'(e[k]);
        for (int k = 0; k < NC; k++) exp_c[k*IW +: IW] = IW'(c[k]);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the sampling edge.
    task automatic launch(input bit ld, input logic [15:0] sd);
        start = 1'b1; seed_load = ld; seed = sd;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
    endtask

    task automatic wait_done(input bit pulses, output int lat, output bit stable);
        lat = -1;
        stable = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (edge_order !== pub_e || center_order !== pub_c) stable = 1'b0;
            start = pulses && (n == 5 || n == 20);
        end
        start = 1'b0;
    endtask

    task automatic finish_checks(input string tag, input int lat, input bit stable);
        check_int({tag, " latency"}, lat, LAT);
        check_int({tag, " stable"}, int'(stable), 1);
        check_vec({tag, " edge_order"}, 128'(edge_order), 128'(exp_e));
        check_vec({tag, " center_order"}, 128'(center_order), 128'(exp_c));
        pub_e = exp_e;
        pub_c = exp_c;
    endtask

    function automatic bit perm_ok(input logic [127:0] v, input int n);
        int cnt[NE];
        int id;
        for (int k = 0; k < NE; k++) cnt[k] = 0;
        for (int k = 0; k < n; k++) begin
            id = int'(v[k*IW +: IW]);
            if (id >= n) return 1'b0;
            cnt[id]++;
        end
        for (int k = 0; k < n; k++) if (cnt[k] != 1) return 1'b0;
        return 1'b1;
    endfunction

    typedef struct {
        bit          ld;
        logic [15:0] sd;
        logic [15:0] eff;   // LFSR value the shuffle must start from
        int          lat;
    } vec_t;

    vec_t vecs[6];
    int   hist[NE][NE];

    initial begin
        int  lat;
        bit  stable;
        int  extra;
        int  empty;
        int  v;

        vecs[0] = '{1'b1, 16'h0000, 16'hACE1, LAT};
        vecs[1] = '{1'b1, 16'h1234, 16'h1234, LAT};
        vecs[2] = '{1'b1, 16'hACE1, 16'hACE1, LAT};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, LAT};
        vecs[4] = '{1'b1, 16'h0001, 16'h0001, LAT};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, LAT};

        for (int k = 0; k < NE; k++) ident_e[k*IW +: IW] = IW'(k);
        for (int k = 0; k < NC; k++) ident_c[k*IW +: IW] = IW'(k);
        for (int a = 0; a < NE; a++) for (int b = 0; b < NE; b++) hist[a][b] = 0;
        pub_e = ident_e;
        pub_c = ident_c;

        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check_vec("reset edge_order", 128'(edge_order), 128'(ident_e));
        check_vec("reset center_order", 128'(center_order), 128'(ident_c));
        check_int("reset valid", int'(valid), 0);
        check_int("reset busy", int'(busy), 0);
        check_int("reset done", int'(done), 0);

        // Handshake and latency, default seed sequence
        launch(1'b0, 16'h0);
        model_shuffle(m_lfsr);
        check_int("hs busy after start", int'(busy), 1);
        wait_done(1'b0, lat, stable);
        finish_checks("hs", lat, stable);
        check_int("hs busy at done", int'(busy), 0);
        @(posedge clk); #1;
        check_int("hs done width", int'(done), 0);
        check_int("hs valid held", int'(valid), 1);

        // Seed table: seed_load together with start
        foreach (vecs[i]) begin
            launch(vecs[i].ld, vecs[i].sd);
            model_shuffle(vecs[i].eff);
            wait_done(1'b0, lat, stable);
            check_int($sformatf("seed %h latency", vecs[i].sd), lat, vecs[i].lat);
            check_vec($sformatf("seed %h edge", vecs[i].sd), 128'(edge_order), 128'(exp_e));
            check_vec($sformatf("seed %h center", vecs[i].sd), 128'(center_order), 128'(exp_c));
            pub_e = exp_e;
            pub_c = exp_c;
        end

        // Start pulses while busy are ignored; outputs hold until publish
        launch(1'b0, 16'h0);
        model_shuffle(m_lfsr);
        wait_done(1'b1, lat, stable);
        finish_checks("ignored start", lat, stable);
        extra = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check_int("ignored start extra done", extra, 0);

        // Reset in the middle of a shuffle
        launch(1'b0, 16'h0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_vec("midrst edge_order", 128'(edge_order), 128'(ident_e));
        check_vec("midrst center_order", 128'(center_order), 128'(ident_c));
        check_int("midrst valid", int'(valid), 0);
        check_int("midrst busy", int'(busy), 0);
        check_int("midrst done", int'(done), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        pub_e = ident_e;
        pub_c = ident_c;
        launch(1'b0, 16'h0);
        model_shuffle(m_lfsr);
        wait_done(1'b0, lat, stable);
        finish_checks("after midrst", lat, stable);

        // Randomized back-to-back and gapped shuffles with occasional reseeding
        for (int it = 0; it < 1000; it++) begin
            bit          ld;
            logic [15:0] sd;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            ld = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
            launch(ld, sd);
            model_shuffle(m_lfsr);
            wait_done(1'b0, lat, stable);
            finish_checks($sformatf("rand %0d", it), lat, stable);
            check_int($sformatf("rand %0d edge perm", it), int'(perm_ok(128'(edge_order), NE)), 1);
            check_int($sformatf("rand %0d center perm", it),
                      int'(perm_ok(128'(center_order), NC)), 1);
            for (int k = 0; k < NE; k++) begin
                v = int'(edge_order[k*IW +: IW]);
                if (v < NE) hist[k][v]++;
            end
            if (lat < 0) break;
        end

        empty = 0;
        for (int a = 0; a < NE; a++) for (int b = 0; b < NE; b++) if (hist[a][b] == 0) empty++;
        check_int("edge histogram empty bins", empty, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
